multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle FSM that sequences one instruction at a time through FETCH, DECODE,
//  EXECUTE, MEMORY and WRITEBACK around the shared single-port RAM, ALU and register bank.
//  Consumes the decoded controls (ramconfig, regbankconfig, regsource, pcconfig) and turns
//  them into per-cycle strobes: IR load, RAM request/write, regbank write, PC write.
//  Sits between the control unit and the datapath enables.
// PARAMETERS
//  TIMEOUT   16  max cycles waiting on ram_ready in FETCH/MEMORY before ERROR (>=2)
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  run            in   1      1 = keep issuing instructions; sampled in IDLE and WRITEBACK
//  ram_ready      in   1      RAM completes current request this cycle
//  ramconfig      in   1      decoded: 1 = store
//  regbankconfig  in   1      decoded: 1 = instruction writes a register
//  regsource      in   2      decoded write-back source (`REGSRC_ALU/`REGSRC_LOAD/`REGSRC_PC)
//  pcconfig       in   2      decoded PC mode (`PC_NORMAL/`PCSET_STEP/`PCSET_REF)
//  branch_taken   in   1      ALU compare result, valid in EXECUTE..WRITEBACK
//  imem_req       out  1      instruction fetch request (RAM addressed by PC)
//  ir_load        out  1      latch RAM data into instruction register
//  dmem_req       out  1      data access request (RAM addressed by ALU result)
//  dmem_we        out  1      data write enable, only with dmem_req
//  reg_write      out  1      register-bank write strobe
//  pc_write       out  1      PC update strobe
//  pc_select      out  2      PC mode applied with pc_write
//  state          out  3      current state encoding (for debug/bench)
//  busy           out  1      state not IDLE/ERROR
//  error          out  1      sticky RAM timeout flag
//  retired        out  CNT_W  instructions completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 ERROR=7.
//  Reset: state=IDLE, wait counter=0, retired=0, error=0; every output 0 (state=0).
//  Reset wins over all events incl. mid-MEMORY; no pc_write/reg_write in reset cycle.
//  Strobes are decoded from current state (and ram_ready), no extra register stage.
//  IDLE: all strobes 0; run=1 -> FETCH next cycle.
//  FETCH: imem_req=1 held until ram_ready; in ram_ready cycle ir_load=1, -> DECODE.
//  DECODE: 1 cycle, strobes 0; control inputs settle from new IR; -> EXECUTE.
//  EXECUTE: 1 cycle; if ramconfig=1 or regsource=`REGSRC_LOAD -> MEMORY, else -> WRITEBACK.
//  MEMORY: dmem_req=1, dmem_we=ramconfig, held stable until ram_ready; then -> WRITEBACK.
//  WRITEBACK: pc_write=1; reg_write=regbankconfig; retired+=1;
//   pc_select = (pcconfig==`PCSET_STEP && !branch_taken) ? `PC_NORMAL : pcconfig;
//   next = run ? FETCH : IDLE.
//  Latency with ram_ready tied 1: non-memory instr 4 cycles, load/store 5 cycles.
//  Wait counter: cleared on entry to FETCH/MEMORY, +1 per cycle without ram_ready;
//   ram_ready in the cycle counter==TIMEOUT-1 still completes; otherwise at
//   counter==TIMEOUT-1 -> ERROR. ERROR: all strobes 0, error=1, held until reset.
//  ram_ready outside FETCH/MEMORY is ignored. run deassert mid-instruction: instruction
//   completes, IDLE entered after WRITEBACK. Control inputs sampled only in their state.
//  pc_select is 0 whenever pc_write=0. retired wraps all-ones -> 0 without flag.
// TESTING
//  1 reset, run=1, ram_ready=1, ALU instr (regbankconfig=1, `PC_NORMAL) -> states 1,2,3,5;
//    reg_write=pc_write=1 in cycle 4 only, retired=1, then back to FETCH.
//  2 load, ram_ready low 3 cycles in MEMORY -> dmem_req=1 for 4 cycles, dmem_we=0,
//    reg_write in next WRITEBACK; store same path gives dmem_we=1, reg_write=0.
//  3 branch `PCSET_STEP: branch_taken=0 -> pc_select=`PC_NORMAL; =1 -> `PCSET_STEP; reg_write=0.
//  4 TIMEOUT=8, ram_ready stuck 0 in FETCH -> ERROR after 8 cycles, error=1, no strobes
//    while run=1; only reset clears.
//  5 reset asserted during MEMORY -> next cycle state=0, all outputs 0, retired=0.
//  6 run dropped in EXECUTE -> that instr retires (pc_write once), then IDLE, busy=0;
//    preload retired=2^CNT_W-1 via long run (CNT_W=4) -> wraps to 0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Handshake bundle between the multicycle sequencer and its environment.
//   master : control unit / datapath side. Drives run, ram_ready and the
//            decoded instruction controls; observes strobes and status.
//   slave  : the sequencer. Consumes the controls; drives per-cycle strobes,
//            debug state, busy, sticky error and the retired-instruction count.
// CNT_W sets the width of the retired counter and must match the sequencer.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  // environment -> sequencer
  logic             run;
  logic             ram_ready;
  logic             ramconfig;      // 1 = store
  logic             regbankconfig;  // 1 = instruction writes a register
  logic [1:0]       regsource;      // write-back source
  logic [1:0]       pcconfig;       // PC update mode
  logic             branch_taken;
  // sequencer -> datapath enables and status
  logic             imem_req;
  logic             ir_load;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_write;
  logic             pc_write;
  logic [1:0]       pc_select;
  logic [2:0]       state;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] retired;

  modport master (
    output run, ram_ready, ramconfig, regbankconfig, regsource, pcconfig, branch_taken,
    input  imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, pc_select,
    input  state, busy, error, retired
  );

  modport slave (
    input  run, ram_ready, ramconfig, regbankconfig, regsource, pcconfig, branch_taken,
    output imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, pc_select,
    output state, busy, error, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer. Steps one instruction at a time through
// FETCH, DECODE, EXECUTE, optional MEMORY, and WRITEBACK around a shared
// single-port RAM, turning decoded controls into per-cycle datapath strobes.
// Ports:
//   clk   : rising-edge clock for all state
//   reset : synchronous, active-high; forces IDLE, clears counters and error
//   bus   : multicycle_sequencer_if.slave -- run/ram_ready/decoded controls in;
//           imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write,
//           pc_select, state, busy, error, retired out
// Parameters:
//   TIMEOUT : cycles allowed waiting on ram_ready in FETCH/MEMORY (>= 2)
//   CNT_W   : retired-instruction counter width (wraps silently)
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.slave  bus
);

  localparam logic [1:0] REGSRC_LOAD = 2'd1;
  localparam logic [1:0] PC_NORMAL   = 2'd0;
  localparam logic [1:0] PCSET_STEP  = 2'd1;

  localparam int              WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic       imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write;
  logic [1:0] pc_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    error_d   = error_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PC_NORMAL;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // A response in the last allowed wait cycle still counts.
        if (bus.ram_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (bus.ramconfig || (bus.regsource == REGSRC_LOAD)) begin
          state_d = S_MEMORY;
          wait_d  = '0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = bus.ramconfig;
        if (bus.ram_ready) begin
          state_d = S_WRITEBACK;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        pc_write  = 1'b1;
        reg_write = bus.regbankconfig;
        // A not-taken conditional step falls back to sequential PC.
        pc_sel    = ((bus.pcconfig == PCSET_STEP) && !bus.branch_taken) ? PC_NORMAL
                                                                        : bus.pcconfig;
        retired_d = retired_q + 1'b1;
        if (bus.run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d = S_ERROR;
        error_d = 1'b1;
      end
    endcase
  end

  // Strobes are suppressed in the reset cycle so nothing reaches the datapath
  // while the FSM is being forced back to IDLE.
  assign bus.imem_req  = imem_req  & ~reset;
  assign bus.ir_load   = ir_load   & ~reset;
  assign bus.dmem_req  = dmem_req  & ~reset;
  assign bus.dmem_we   = dmem_we   & ~reset;
  assign bus.reg_write = reg_write & ~reset;
  assign bus.pc_write  = pc_write  & ~reset;
  assign bus.pc_select = (pc_write & ~reset) ? pc_sel : 2'b00;
  assign bus.state     = state_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.error     = error_q;
  assign bus.retired   = retired_q;

endmodule
